multi_debounce_counter: RTL and testbench
=========================================

MULTI_DEBOUNCE_COUNTER -- requirements
Module: multi_debounce_counter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent switch channels, range 1..16.
REQ-002 SHALL have parameter STABLE_CYCLES, default 1_000_000: clock cycles a synchronised input must hold a new level before it is accepted (10 ms at 100 MHz), minimum 2.
REQ-003 SHALL have parameter CNT_W, default 16: width of each per-channel press counter, range 1..16.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is rising-edge triggered.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port swin, input, NUM_CH: raw asynchronous switch levels.
REQ-007 SHALL have port mode, input, 2: LED display mode.
REQ-008 SHALL have port sel, input, 4: channel shown in count mode.
REQ-009 SHALL have port clr, input, 1: synchronous clear of all press counters and toggle states.
REQ-010 SHALL have port db_out, output, NUM_CH: debounced levels.
REQ-011 SHALL have port rise, output, NUM_CH: one-cycle pulse per accepted 0->1 transition.
REQ-012 SHALL have port leds, output, 16: display vector.

Function
REQ-013 SHALL pass each swin bit through a 2-flop synchroniser before any other logic.
REQ-014 SHALL keep one stability counter per channel:
- synchronised level equals db_out: counter clears to 0.
- synchronised level differs from db_out: counter increments.
- counter reaches STABLE_CYCLES-1 while the level still differs: db_out takes the new level and the counter clears.
REQ-015 SHALL give a clean step on swin a latency of exactly STABLE_CYCLES+2 clock edges to db_out.
REQ-016 SHALL clear the stability counter and leave db_out unchanged on any glitch shorter than STABLE_CYCLES synchronised cycles.
REQ-017 SHALL assert rise[i] for exactly one cycle, registered, in the cycle after db_out[i] goes 0->1.
REQ-018 SHALL never assert rise on a 1->0 transition.
REQ-019 SHALL increment press counter i by 1 on each rise[i], modulo 2^CNT_W (wraps to 0).
REQ-020 SHALL invert toggle bit i on each rise[i].
REQ-021 SHALL give clr priority over a coincident rise: counter = 0 and toggle = 0, and that press is lost.
REQ-022 SHALL drive leds, registered one cycle after its sources, by mode:
- 0 (COUNT): press counter[sel], zero-extended to 16 bits; sel >= NUM_CH shows 0.
- 1 (LEVEL): db_out, zero-extended.
- 2 (TOGGLE): toggle bits, zero-extended.
- 3 (WALK): one-hot position register starting at bit 0; rotates left by one on any rise in a cycle (several coincident rises rotate it once); bit 15 wraps to bit 0.
REQ-023 SHALL reflect a mode or sel change on leds on the next clock edge.

Reset
REQ-024 SHALL, while rst=0 at a rising edge, clear the synchronisers, stability counters, db_out, rise, press counters and toggle bits to 0, set the WALK register to 16'h0001, and clear leds to 0.
REQ-025 SHALL abort any in-progress debounce when reset is asserted mid-count; after release a stable level needs a full STABLE_CYCLES+2 again.
REQ-026 SHALL not generate a rise pulse because of reset release itself, even when swin is high.

Structure
REQ-027 SHALL place the mode encodings (COUNT, LEVEL, TOGGLE, WALK) and the default STABLE_CYCLES constant in the shared package multi_debounce_pkg.
REQ-028 SHALL implement the synchroniser, stability counter, db_out and rise of one channel as sub-module debounce_channel, instantiated NUM_CH times by a generate loop.
REQ-029 SHALL size each stability counter as clog2(STABLE_CYCLES) bits; no other arithmetic exceeds CNT_W or 16 bits.

Verification (benches run with STABLE_CYCLES=8, NUM_CH=4, CNT_W=4)
REQ-030 SHALL cover clean press: swin[0] 0->1 held 20 cycles -> db_out[0]=1 exactly 10 edges later; rise[0] is a single pulse; mode 0, sel 0 gives leds=16'h0001.
REQ-031 SHALL cover bounce: swin[1] toggles every 3 cycles for 30 cycles then holds 0 -> db_out[1] stays 0 and rise[1] never asserts.
REQ-032 SHALL cover wrap: 17 clean presses on channel 2 -> mode 0, sel 2 gives leds=16'h0001; mode 2 gives bit 2 = 1.
REQ-033 SHALL cover clear collision: clr asserted in the same cycle as rise[3] -> counter 3 = 0, toggle 3 = 0 next cycle.
REQ-034 SHALL cover WALK: rises on channels 0 and 1 in the same cycle -> leds goes 16'h0001 -> 16'h0002 (single rotate); 16 further presses return it to 16'h0002.
REQ-035 SHALL cover mid-count reset: swin[0]=1 for 5 cycles, then rst=0 for 1 cycle -> db_out[0] stays 0 until 10 edges after reset release, and no rise occurs at release.

Source files
------------

// File: rtl/multi_debounce_pkg.sv
// multi_debounce_pkg: shared display-mode encodings and default debounce time
package multi_debounce_pkg;
  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_LEVEL  = 2'd1,
    MODE_TOGGLE = 2'd2,
    MODE_WALK   = 2'd3
  } mode_e;
  // 10 ms at 100 MHz
  localparam int DEF_STABLE_CYCLES = 1_000_000;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: 2-flop synchroniser, stability counter, debounced level and rise pulse
module debounce_channel #(
  parameter int STABLE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw,
  output logic o_db,
  output logic o_rise
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  logic r_s1, r_s2, r_db, r_db_d, r_rise;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk)
    if (!rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_db   <= 1'b0;
      r_db_d <= 1'b0;
      r_rise <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_sw;
      r_s2   <= r_s1;
      r_db_d <= r_db;
      r_rise <= r_db & ~r_db_d;
      if (r_s2 == r_db) r_cnt <= '0;
      else if (r_cnt == LAST) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + CW'(1);
    end
  assign o_db   = r_db;
  assign o_rise = r_rise;
endmodule

// File: rtl/multi_debounce_counter.sv
// multi_debounce_counter: per-channel switch debouncing with press counters,
// toggle bits and a registered 16-bit LED display selected by mode
module multi_debounce_counter
  import multi_debounce_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] swin,
  input  logic [1:0]        mode,
  input  logic [3:0]        sel,
  input  logic              clr,
  output logic [NUM_CH-1:0] db_out,
  output logic [NUM_CH-1:0] rise,
  output logic [15:0]       leds
);
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_tog;
  logic [15:0]       r_walk, r_leds, w_leds_nxt;
  logic [CNT_W-1:0]  w_cnt_sel;
  genvar c;
  for (c = 0; c < NUM_CH; c++) begin : g_ch
    debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .i_sw  (swin[c]),
      .o_db  (db_out[c]),
      .o_rise(rise[c])
    );
  end
  // clr wins over a coincident rise, so that press is dropped
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (!rst || clr) r_cnt[i] <= '0;
      else if (rise[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
    r_tog <= (!rst || clr) ? '0 : r_tog ^ rise;
  end
  always_comb begin
    w_cnt_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (sel == 4'(i)) w_cnt_sel = r_cnt[i];
  end
  assign w_leds_nxt = mode == MODE_COUNT  ? 16'(w_cnt_sel) :
                      mode == MODE_LEVEL  ? 16'(db_out)    :
                      mode == MODE_TOGGLE ? 16'(r_tog)     : r_walk;
  // coincident rises rotate the walk position only once
  always_ff @(posedge clk)
    if (!rst) begin
      r_walk <= 16'h0001;
      r_leds <= '0;
    end else begin
      r_walk <= |rise ? {r_walk[14:0], r_walk[15]} : r_walk;
      r_leds <= w_leds_nxt;
    end
  assign leds = r_leds;
endmodule

// File: tb/tb_multi_debounce_counter.sv
// tb_multi_debounce_counter: directed and random scenarios checked against a
// window-based reference model of the debouncer and display
module tb_multi_debounce_counter;
  localparam int NCH = 4;
  localparam int SC  = 8;
  localparam int CW  = 4;
  logic clk = 0, rst = 0, clr = 0;
  logic [3:0] swin = '0, sel = '0;
  logic [1:0] mode = '0;
  logic [3:0] db_out, rise;
  logic [15:0] leds;
  int vecs = 0, errs = 0;

  multi_debounce_counter #(.NUM_CH(NCH), .STABLE_CYCLES(SC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .swin(swin), .mode(mode), .sel(sel), .clr(clr),
    .db_out(db_out), .rise(rise), .leds(leds)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted at edge n when the swin samples taken
  // at edges n-9..n-2 (two-flop delay, SC samples) all differ from the current
  // debounced level and no reset edge falls inside that window.
  logic [3:0] hist[$];
  int n = 0, last_rst = 0;
  int m_cnt[NCH];
  logic [3:0] m_db = '0, m_rose = '0, m_rise = '0, m_tog = '0;
  logic [15:0] m_walk = 16'h0001, m_leds = '0;

  always @(posedge clk) begin
    logic [15:0] lv;
    logic [3:0] flip;
    if (!rst) begin
      hist.push_back('0);
      if (n > 0) hist[n-1] = '0;
      last_rst = n;
      m_db = '0; m_rose = '0; m_rise = '0; m_tog = '0;
      m_walk = 16'h0001; m_leds = '0;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    end else begin
      hist.push_back(swin);
      case (mode)
        2'd0:    lv = (sel < NCH) ? 16'(m_cnt[sel]) : 16'h0;
        2'd1:    lv = 16'(m_db);
        2'd2:    lv = 16'(m_tog);
        default: lv = m_walk;
      endcase
      m_leds = lv;
      for (int i = 0; i < NCH; i++)
        if (clr) m_cnt[i] = 0;
        else if (m_rise[i]) m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
      m_tog = clr ? '0 : m_tog ^ m_rise;
      if (|m_rise) m_walk = {m_walk[14:0], m_walk[15]};
      flip = '0;
      if (n - 7 > last_rst && n >= 9)
        for (int i = 0; i < NCH; i++) begin
          flip[i] = 1'b1;
          for (int k = 2; k <= 9; k++)
            if (hist[n-k][i] == m_db[i]) flip[i] = 1'b0;
        end
      m_rise = m_rose;
      m_rose = flip & ~m_db;
      m_db   = m_db ^ flip;
    end
    n++;
  end

  task automatic test_reset;
    rst = 0; swin = 4'hF; mode = 2'd0; sel = 4'd0; clr = 0;
    repeat (3) begin
      @(negedge clk);
      vecs++;
      if ({db_out, rise, leds} !== 24'h0) begin
        errs++;
        $display("FAIL reset: db/rise/leds=%h/%h/%h required 0/0/0000", db_out, rise, leds);
      end
    end
    swin = '0; rst = 1; mode = 2'd3;
    @(negedge clk);
    vecs++;
    if (leds !== 16'h0001) begin
      errs++;
      $display("FAIL walk_init: leds=%h required 0001", leds);
    end
    mode = 2'd0;
    repeat (12) begin
      @(negedge clk);
      vecs++;
      if ({db_out, rise, leds} !== {m_db, m_rise, m_leds}) begin
        errs++;
        $display("FAIL reset_idle: db/rise/leds=%h/%h/%h required %h/%h/%h", db_out, rise, leds, m_db, m_rise, m_leds);
      end
    end
  endtask

  task automatic test_clean_press;
    int pulses = 0;
    mode = 2'd0; sel = 4'd0; swin[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      vecs++;
      if ({db_out, rise, leds} !== {m_db, m_rise, m_leds}) begin
        errs++;
        $display("FAIL clean_model: db/rise/leds=%h/%h/%h required %h/%h/%h", db_out, rise, leds, m_db, m_rise, m_leds);
      end
      vecs++;
      if (db_out[0] !== 1'(k >= 10)) begin
        errs++;
        $display("FAIL clean_latency: edge %0d db_out[0]=%b required %b", k, db_out[0], k >= 10);
      end
      pulses += int'(rise[0]);
    end
    vecs++;
    if (pulses != 1) begin
      errs++;
      $display("FAIL clean_pulse: rise[0] pulses=%0d required 1", pulses);
    end
    vecs++;
    if (leds !== 16'h0001) begin
      errs++;
      $display("FAIL clean_count: leds=%h required 0001", leds);
    end
    swin[0] = 1'b0;
    repeat (14) begin
      @(negedge clk);
      vecs++;
      if ({db_out, rise, leds} !== {m_db, m_rise, m_leds}) begin
        errs++;
        $display("FAIL clean_release: db/rise/leds=%h/%h/%h required %h/%h/%h", db_out, rise, leds, m_db, m_rise, m_leds);
      end
    end
  endtask

  task automatic test_bounce;
    for (int k = 0; k < 45; k++) begin
      swin[1] = (k < 30) ? 1'((k / 3) % 2 == 0) : 1'b0;
      @(negedge clk);
      vecs++;
      if (db_out[1] !== 1'b0 || rise[1] !== 1'b0) begin
        errs++;
        $display("FAIL bounce: db_out[1]/rise[1]=%b/%b required 0/0", db_out[1], rise[1]);
      end
      vecs++;
      if ({db_out, rise, leds} !== {m_db, m_rise, m_leds}) begin
        errs++;
        $display("FAIL bounce_model: db/rise/leds=%h/%h/%h required %h/%h/%h", db_out, rise, leds, m_db, m_rise, m_leds);
      end
    end
  endtask

  task automatic test_wrap;
    mode = 2'd0; sel = 4'd2;
    for (int p = 0; p < 34; p++) begin
      swin[2] = 1'(p % 2 == 0);
      repeat (12) begin
        @(negedge clk);
        vecs++;
        if ({db_out, rise, leds} !== {m_db, m_rise, m_leds}) begin
          errs++;
          $display("FAIL wrap_model: db/rise/leds=%h/%h/%h required %h/%h/%h", db_out, rise, leds, m_db, m_rise, m_leds);
        end
      end
    end
    vecs++;
    if (leds !== 16'h0001) begin
      errs++;
      $display("FAIL wrap_count: leds=%h required 0001", leds);
    end
    mode = 2'd2;
    @(negedge clk);
    vecs++;
    if (leds[2] !== 1'b1) begin
      errs++;
      $display("FAIL wrap_toggle: leds=%h required bit2=1", leds);
    end
  endtask

  task automatic test_clear_collision;
    bit seen = 0;
    mode = 2'd0; sel = 4'd3; swin[3] = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      vecs++;
      if ({db_out, rise, leds} !== {m_db, m_rise, m_leds}) begin
        errs++;
        $display("FAIL clr_model: db/rise/leds=%h/%h/%h required %h/%h/%h", db_out, rise, leds, m_db, m_rise, m_leds);
      end
      seen = rise[3];
    end
    vecs++;
    if (!seen) begin
      errs++;
      $display("FAIL clr_wait: rise[3]=0 after 20 cycles required 1");
    end
    clr = 1;
    @(negedge clk);
    clr = 0;
    @(negedge clk);
    vecs++;
    if (leds !== 16'h0000) begin
      errs++;
      $display("FAIL clr_count: leds=%h required 0000", leds);
    end
    mode = 2'd2;
    @(negedge clk);
    vecs++;
    if (leds[3] !== 1'b0) begin
      errs++;
      $display("FAIL clr_toggle: leds=%h required bit3=0", leds);
    end
    swin[3] = 1'b0;
    repeat (12) begin
      @(negedge clk);
      vecs++;
      if ({db_out, rise, leds} !== {m_db, m_rise, m_leds}) begin
        errs++;
        $display("FAIL clr_settle: db/rise/leds=%h/%h/%h required %h/%h/%h", db_out, rise, leds, m_db, m_rise, m_leds);
      end
    end
  endtask

  task automatic test_walk;
    rst = 0; swin = '0;
    @(negedge clk);
    rst = 1; mode = 2'd3; swin = 4'b0011;
    repeat (14) begin
      @(negedge clk);
      vecs++;
      if ({db_out, rise, leds} !== {m_db, m_rise, m_leds}) begin
        errs++;
        $display("FAIL walk_model: db/rise/leds=%h/%h/%h required %h/%h/%h", db_out, rise, leds, m_db, m_rise, m_leds);
      end
    end
    vecs++;
    if (leds !== 16'h0002) begin
      errs++;
      $display("FAIL walk_coincident: leds=%h required 0002", leds);
    end
    swin[1] = 1'b0;
    for (int p = 0; p < 32; p++) begin
      swin[0] = 1'(p % 2 == 1);
      repeat (12) begin
        @(negedge clk);
        vecs++;
        if ({db_out, rise, leds} !== {m_db, m_rise, m_leds}) begin
          errs++;
          $display("FAIL walk_press: db/rise/leds=%h/%h/%h required %h/%h/%h", db_out, rise, leds, m_db, m_rise, m_leds);
        end
      end
    end
    repeat (2) @(negedge clk);
    vecs++;
    if (leds !== 16'h0002) begin
      errs++;
      $display("FAIL walk_wrap: leds=%h required 0002", leds);
    end
  endtask

  task automatic test_mid_reset;
    rst = 0; swin = '0; mode = 2'd1;
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    swin[0] = 1'b1;
    repeat (5) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      vecs++;
      if (db_out[0] !== 1'(k >= 10) || (k <= 10 && rise[0] !== 1'b0)) begin
        errs++;
        $display("FAIL mid_reset: edge %0d db_out[0]/rise[0]=%b/%b required %b/0", k, db_out[0], rise[0], k >= 10);
      end
      vecs++;
      if ({db_out, rise, leds} !== {m_db, m_rise, m_leds}) begin
        errs++;
        $display("FAIL mid_reset_model: db/rise/leds=%h/%h/%h required %h/%h/%h", db_out, rise, leds, m_db, m_rise, m_leds);
      end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 9) == 0) swin[i] = ~swin[i];
      if (k % 20 == 0) begin
        mode = 2'($urandom_range(0, 3));
        sel  = 4'($urandom_range(0, 15));
      end
      clr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 199) != 0);
      @(negedge clk);
      vecs++;
      if ({db_out, rise, leds} !== {m_db, m_rise, m_leds}) begin
        errs++;
        $display("FAIL random: cycle %0d db/rise/leds=%h/%h/%h required %h/%h/%h", k, db_out, rise, leds, m_db, m_rise, m_leds);
      end
    end
    rst = 1; clr = 0;
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_wrap;
    test_clear_collision;
    test_walk;
    test_mid_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
